// File: rtl/multicycle_control_if.sv
// ---------------------------------------------------------------------------
// multicycle_control_if
// Control bundle between the multi-cycle MIPS control FSM and its datapath.
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

interface multicycle_control_if #(
  parameter int OPCODE_SIZE = 6,
  parameter int ALU_OP_SIZE = 2,
  parameter int STATE_SIZE  = 4
);
  logic [OPCODE_SIZE-1:0] opcode;
  logic                   mem_ready;
  logic                   PC_write;
  logic                   PC_write_cond;
  logic [1:0]             PC_source;
  logic                   I_or_D;
  logic                   mem_read;
  logic                   mem_write;
  logic                   IR_write;
  logic                   reg_dst;
  logic                   mem_to_reg;
  logic                   reg_write;
  logic                   ALU_src_A;
  logic [1:0]             ALU_src_B;
  logic [ALU_OP_SIZE-1:0] ALU_op;
  logic                   illegal_op;
  logic [STATE_SIZE-1:0]  state;

  // Controller side: consumes opcode/handshake, drives all datapath controls.
  modport master (
    input  opcode, mem_ready,
    output PC_write, PC_write_cond, PC_source, I_or_D, mem_read, mem_write,
           IR_write, reg_dst, mem_to_reg, reg_write, ALU_src_A, ALU_src_B,
           ALU_op, illegal_op, state
  );

  // Datapath side.
  modport slave (
    output opcode, mem_ready,
    input  PC_write, PC_write_cond, PC_source, I_or_D, mem_read, mem_write,
           IR_write, reg_dst, mem_to_reg, reg_write, ALU_src_A, ALU_src_B,
           ALU_op, illegal_op, state
  );
endinterface

`default_nettype wire

// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control
// Main control FSM of the multi-cycle MIPS datapath (R-type, LW, SW, BEQ,
// J, ADDI). Optional macro ILLEGAL_TRAP_EN: illegal opcodes enter a sticky
// TRAP state instead of being executed as a NOP.
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module multicycle_control #(
  parameter int OPCODE_SIZE = 6,
  parameter int ALU_OP_SIZE = 2,
  parameter int STATE_SIZE  = 4
) (
  input  wire                  clk,
  input  wire                  reset_n,
  multicycle_control_if.master bus
);

  typedef enum logic [STATE_SIZE-1:0] {
    S_RESET     = STATE_SIZE'(0),
    S_FETCH     = STATE_SIZE'(1),
    S_DECODE    = STATE_SIZE'(2),
    S_MEM_ADDR  = STATE_SIZE'(3),
    S_MEM_READ  = STATE_SIZE'(4),
    S_MEM_WB    = STATE_SIZE'(5),
    S_MEM_WRITE = STATE_SIZE'(6),
    S_EXECUTE   = STATE_SIZE'(7),
    S_R_WB      = STATE_SIZE'(8),
    S_BRANCH    = STATE_SIZE'(9),
    S_JUMP      = STATE_SIZE'(10),
    S_ADDI_EXEC = STATE_SIZE'(11),
    S_ADDI_WB   = STATE_SIZE'(12),
    S_TRAP      = STATE_SIZE'(13)
  } state_t;

  localparam logic [OPCODE_SIZE-1:0] OP_RTYPE = OPCODE_SIZE'(0);
  localparam logic [OPCODE_SIZE-1:0] OP_J     = OPCODE_SIZE'(2);
  localparam logic [OPCODE_SIZE-1:0] OP_BEQ   = OPCODE_SIZE'(4);
  localparam logic [OPCODE_SIZE-1:0] OP_ADDI  = OPCODE_SIZE'(8);
  localparam logic [OPCODE_SIZE-1:0] OP_LW    = OPCODE_SIZE'(35);
  localparam logic [OPCODE_SIZE-1:0] OP_SW    = OPCODE_SIZE'(43);

  localparam logic [ALU_OP_SIZE-1:0] ALU_ADD   = ALU_OP_SIZE'(0);
  localparam logic [ALU_OP_SIZE-1:0] ALU_SUB   = ALU_OP_SIZE'(1);
  localparam logic [ALU_OP_SIZE-1:0] ALU_FUNCT = ALU_OP_SIZE'(2);

  // Moore-decoded controls. PC_write/IR_write of FETCH are not here because
  // they follow mem_ready combinationally; the JUMP PC load is.
  typedef struct packed {
    logic                   pc_write_jump;
    logic                   pc_write_cond;
    logic [1:0]             pc_source;
    logic                   i_or_d;
    logic                   mem_read;
    logic                   mem_write;
    logic                   reg_dst;
    logic                   mem_to_reg;
    logic                   reg_write;
    logic                   alu_src_a;
    logic [1:0]             alu_src_b;
    logic [ALU_OP_SIZE-1:0] alu_op;
    logic                   illegal;
  } ctrl_t;

  state_t state;
  state_t state_next;
  ctrl_t  ctrl;

  // Next-state selection; mem_ready only matters in the three memory states.
  function automatic state_t next_of(state_t s, logic [OPCODE_SIZE-1:0] op,
                                     logic rdy);
    state_t n;
    n = S_RESET;
    case (s)
      S_RESET:     n = S_FETCH;
      S_FETCH:     n = rdy ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: n = S_MEM_ADDR;
          OP_RTYPE:     n = S_EXECUTE;
          OP_BEQ:       n = S_BRANCH;
          OP_J:         n = S_JUMP;
          OP_ADDI:      n = S_ADDI_EXEC;
`ifdef ILLEGAL_TRAP_EN
          default:      n = S_TRAP;
`else
          default:      n = S_FETCH;
`endif
        endcase
      end
      // Opcode is guaranteed to be LW or SW here; anything else restarts.
      S_MEM_ADDR:  n = (op == OP_LW) ? S_MEM_READ :
                       (op == OP_SW) ? S_MEM_WRITE : S_FETCH;
      S_MEM_READ:  n = rdy ? S_MEM_WB : S_MEM_READ;
      S_MEM_WB:    n = S_FETCH;
      S_MEM_WRITE: n = rdy ? S_FETCH : S_MEM_WRITE;
      S_EXECUTE:   n = S_R_WB;
      S_R_WB:      n = S_FETCH;
      S_BRANCH:    n = S_FETCH;
      S_JUMP:      n = S_FETCH;
      S_ADDI_EXEC: n = S_ADDI_WB;
      S_ADDI_WB:   n = S_FETCH;
`ifdef ILLEGAL_TRAP_EN
      S_TRAP:      n = S_TRAP;
`endif
      default:     n = S_RESET;
    endcase
    return n;
  endfunction

  // Control word for a state; everything not named is 0.
  function automatic ctrl_t decode(state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = 2'b01;
        c.alu_op    = ALU_ADD;
      end
      S_DECODE: begin
        c.alu_src_b = 2'b11;
        c.alu_op    = ALU_ADD;
      end
      S_MEM_ADDR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
        c.alu_op    = ALU_ADD;
      end
      S_MEM_READ: begin
        c.mem_read = 1'b1;
        c.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        c.mem_to_reg = 1'b1;
        c.reg_write  = 1'b1;
      end
      S_MEM_WRITE: begin
        c.mem_write = 1'b1;
        c.i_or_d    = 1'b1;
      end
      S_EXECUTE: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b00;
        c.alu_op    = ALU_FUNCT;
      end
      S_R_WB: begin
        c.reg_dst   = 1'b1;
        c.reg_write = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_op        = ALU_SUB;
        c.pc_write_cond = 1'b1;
        c.pc_source     = 2'b01;
      end
      S_JUMP: begin
        c.pc_write_jump = 1'b1;
        c.pc_source     = 2'b10;
      end
      S_ADDI_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
        c.alu_op    = ALU_ADD;
      end
      S_ADDI_WB: begin
        c.reg_write = 1'b1;
      end
`ifdef ILLEGAL_TRAP_EN
      S_TRAP: begin
        c.illegal = 1'b1;
      end
`endif
      default: c = '0;
    endcase
    return c;
  endfunction

  assign state_next = next_of(state, bus.opcode, bus.mem_ready);

  // State register plus registered control word decoded from the next state,
  // so outputs line up with the state they belong to and clear on reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_RESET;
      ctrl  <= '0;
    end else begin
      state <= state_next;
      ctrl  <= decode(state_next);
    end
  end

  // Fetch completes (PC+4 and IR load) only in the cycle memory answers.
  assign bus.IR_write      = (state == S_FETCH) && bus.mem_ready;
  assign bus.PC_write      = ((state == S_FETCH) && bus.mem_ready) || ctrl.pc_write_jump;
  assign bus.PC_write_cond = ctrl.pc_write_cond;
  assign bus.PC_source     = ctrl.pc_source;
  assign bus.I_or_D        = ctrl.i_or_d;
  assign bus.mem_read      = ctrl.mem_read;
  assign bus.mem_write     = ctrl.mem_write;
  assign bus.reg_dst       = ctrl.reg_dst;
  assign bus.mem_to_reg    = ctrl.mem_to_reg;
  assign bus.reg_write     = ctrl.reg_write;
  assign bus.ALU_src_A     = ctrl.alu_src_a;
  assign bus.ALU_src_B     = ctrl.alu_src_b;
  assign bus.ALU_op        = ctrl.alu_op;
`ifdef ILLEGAL_TRAP_EN
  assign bus.illegal_op    = ctrl.illegal;
`else
  assign bus.illegal_op    = 1'b0;
`endif
  assign bus.state         = state;

endmodule

`default_nettype wire
